main_collect: RTL and testbench
===============================

Name: main_collect

Overview:
- Result-side counterpart of the Main carry-save multiplier round stage.
- Captures the redundant (p, q) pair when the stage pulses done, then adds p + q.
- Reduces the sum modulo m with a bounded number of compare-subtract steps, one per cycle.
- Presents the reduced N-bit product on a valid/ready output channel to the downstream consumer (next pipeline block or host interface).

Parameters:
- N, 512, operand width; p/q are N+1 bits, modulus and result are N bits.
- MAX_SUB, 3, maximum conditional subtractions per result; the sizing assumption is p+q < (MAX_SUB+1)*m.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_p  input  N+1  carry-save sum word from the multiplier stage.
- in_q  input  N+1  carry-save carry word from the multiplier stage.
- in_m  input  N  modulus, sampled together with p/q.
- in_done  input  1  one-cycle pulse from the stage; p/q/m are valid in that cycle.
- clear  input  1  synchronous clear of the sticky flags.
- out_r  output  N  reduced result.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in any state other than IDLE.
- overrun  output  1  sticky; an in_done pulse was dropped.
- range_err  output  1  sticky; the result was not fully reduced, or m == 0.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; out_r=0, out_valid=0, busy=0, overrun=0, range_err=0; internal p/q/m/sum/count cleared. Reset mid-operation abandons the result with no output.
- State IDLE: on in_done=1, register in_p, in_q, in_m and go to ADD.
- State ADD: sum (N+2 bits) <= zero-extended p + q; count <= 0; go to REDUCE.
- State REDUCE, evaluated each cycle:
  - if m == 0: set range_err, go to OUT with sum unchanged;
  - else if sum >= m and count < MAX_SUB: sum <= sum - m, count++, stay in REDUCE;
  - else if sum >= m (count == MAX_SUB): set range_err, go to OUT;
  - else go to OUT.
- State OUT: out_valid=1 and out_r = sum[N-1:0] (registered). out_r and out_valid hold stable while out_ready=0.
  - On out_valid & out_ready: go to IDLE, and out_valid is 0 next cycle.
  - If in_done=1 in the same cycle as the handshake, capture the new operands and go directly to ADD (back-to-back, no dropped pulse).
- Latency: in_done in cycle t; out_valid rises in cycle t+3+k, where k (0..MAX_SUB) is the number of subtractions performed. Worst case is t+3+MAX_SUB.
- in_done while in ADD, REDUCE, or OUT without a handshake: the pulse is ignored, the captured operands are unchanged, and overrun is set.
- clear=1: overrun and range_err go to 0 next cycle unless a setting event occurs in the same cycle; set wins.
- busy = (state != IDLE); it is registered alongside the state.
- Arithmetic is unsigned. The sum never overflows N+2 bits; the compare uses the full N+2-bit sum against zero-extended m.

Decomposition:
- Shared package holds:
  - the state encoding (one-hot localparams IDLE/ADD/REDUCE/OUT, matching the one-hot mode style of the stage FSM);
  - default N;
  - default MAX_SUB.
- One sub-module, cond_sub: combinational compare-subtract. Inputs sum[N+1:0] and m[N-1:0]; outputs ge and diff. Used by the REDUCE state.
- The FSM, registers, and handshake stay in main_collect.

Test Plan (N=8, MAX_SUB=3):
- Basic reduce: in_done at t with p=20, q=15, m=13 -> sum 35, two subtractions; out_valid rises at t+5 with out_r=9, range_err=0.
- No reduction: p=3, q=4, m=13 -> out_r=7 at t+3; with out_ready=1, out_valid is high exactly one cycle.
- Range error: p=300, q=200, m=13 -> three subtractions, sum 461; out_r=205 (461 mod 256) at t+6, range_err=1. Same test with m=0 -> out_r = (p+q)[7:0] and range_err=1.
- Backpressure/back-to-back:
  - hold out_ready=0 for 5 cycles -> out_r and out_valid stable;
  - raise out_ready together with a new in_done (p=1, q=1, m=13) -> second result 2 appears 3 cycles later;
  - overrun stays 0.
- Overrun: in_done during REDUCE -> overrun=1, first result unchanged. A following clear=1 -> overrun=0 next cycle.
- Reset mid-operation: assert reset in REDUCE -> all outputs 0 immediately, no out_valid after release; a new in_done completes normally.

Source files
------------

// File: rtl/main_collect_pkg.sv
// ---------------------------------------------------------------------------
// main_collect_pkg
//   Shared definitions for the carry-save result collector.
//   - state_t       : one-hot FSM state encoding (IDLE/ADD/REDUCE/OUT), in the
//                     same one-hot style as the multiplier round-stage FSM
//   - DEFAULT_N     : default operand width
//   - DEFAULT_MAX_SUB: default bound on compare-subtract steps per result
//   - count_width() : width of the subtraction counter for a given bound
// ---------------------------------------------------------------------------
package main_collect_pkg;

    localparam int DEFAULT_N       = 512;
    localparam int DEFAULT_MAX_SUB = 3;

    // One-hot encoding; each state owns exactly one bit.
    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        ADD    = 4'b0010,
        REDUCE = 4'b0100,
        OUT    = 4'b1000
    } state_t;

    // Counter must be able to hold the value MAX_SUB itself; keep at least
    // one bit so a MAX_SUB of 0 still yields a legal vector.
    function automatic int count_width(input int max_sub);
        return (max_sub < 1) ? 1 : $clog2(max_sub + 1);
    endfunction

endpackage

// File: rtl/main_collect_if.sv
// ---------------------------------------------------------------------------
// main_collect_if
//   Bundles the operand capture inputs, the valid/ready result channel and
//   the status flags of main_collect.
//   Signals:
//     in_p, in_q  [N:0]   carry-save sum / carry words
//     in_m        [N-1:0] modulus
//     in_done             one-cycle pulse, operands valid in that cycle
//     clear               synchronous clear of sticky flags
//     out_r       [N-1:0] reduced result
//     out_valid / out_ready  result handshake
//     busy, overrun, range_err  status
//   Modports:
//     master : the side that supplies operands and consumes results
//     slave  : the collector itself
// ---------------------------------------------------------------------------
interface main_collect_if
    import main_collect_pkg::*;
#(
    parameter int N = DEFAULT_N
);
    logic [N:0]   in_p;
    logic [N:0]   in_q;
    logic [N-1:0] in_m;
    logic         in_done;
    logic         clear;
    logic [N-1:0] out_r;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         overrun;
    logic         range_err;

    modport master (
        output in_p, in_q, in_m, in_done, clear, out_ready,
        input  out_r, out_valid, busy, overrun, range_err
    );

    modport slave (
        input  in_p, in_q, in_m, in_done, clear, out_ready,
        output out_r, out_valid, busy, overrun, range_err
    );
endinterface

// File: rtl/main_collect_cond_sub.sv
// ---------------------------------------------------------------------------
// cond_sub
//   Combinational compare-subtract used by one REDUCE step.
//   Ports:
//     sum  [N+1:0] in   current partial sum (full width, never truncated)
//     m    [N-1:0] in   modulus, zero-extended for the compare
//     ge           out  sum >= m
//     diff [N+1:0] out  sum - m (meaningful only when ge)
// ---------------------------------------------------------------------------
module cond_sub
    import main_collect_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N+1:0] sum,
    input  logic [N-1:0] m,
    output logic         ge,
    output logic [N+1:0] diff
);
    logic [N+1:0] m_ext;

    assign m_ext = {2'b00, m};
    assign ge    = (sum >= m_ext);
    assign diff  = sum - m_ext;

endmodule

// File: rtl/main_collect.sv
// ---------------------------------------------------------------------------
// main_collect
//   Result-side counterpart of the carry-save multiplier round stage.
//   Captures (p, q, m) on in_done, forms p + q, reduces it modulo m with at
//   most MAX_SUB compare-subtract steps (one per cycle), and offers the N-bit
//   result on a valid/ready channel.
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous active-low reset
//     bus    main_collect_if.slave (operands, result handshake, status flags)
//   Timing: in_done in cycle t -> out_valid in cycle t+3+k, k = subtractions.
// ---------------------------------------------------------------------------
module main_collect
    import main_collect_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int MAX_SUB = DEFAULT_MAX_SUB
) (
    input  logic clock,
    input  logic reset,
    main_collect_if.slave bus
);
    localparam int CW = count_width(MAX_SUB);
    localparam logic [CW-1:0] MAX_SUB_C = CW'(MAX_SUB);

    state_t        state_reg, state_next;
    logic [N:0]    p_reg, p_next;
    logic [N:0]    q_reg, q_next;
    logic [N-1:0]  m_reg, m_next;
    logic [N+1:0]  sum_reg, sum_next;
    logic [CW-1:0] count_reg, count_next;
    logic [N-1:0]  out_r_reg, out_r_next;
    logic          out_valid_reg, out_valid_next;
    logic          busy_reg, busy_next;
    logic          overrun_reg, overrun_next;
    logic          range_err_reg, range_err_next;

    logic          capture;
    logic          enter_out;
    logic          range_set;
    logic          overrun_set;
    logic          sub_ge;
    logic [N+1:0]  sub_diff;

    cond_sub #(.N(N)) u_cond_sub (
        .sum  (sum_reg),
        .m    (m_reg),
        .ge   (sub_ge),
        .diff (sub_diff)
    );

    always_comb begin
        state_next     = state_reg;
        p_next         = p_reg;
        q_next         = q_reg;
        m_next         = m_reg;
        sum_next       = sum_reg;
        count_next     = count_reg;
        out_r_next     = out_r_reg;
        out_valid_next = out_valid_reg;
        capture        = 1'b0;
        enter_out      = 1'b0;
        range_set      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (bus.in_done) begin
                    capture    = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                sum_next   = {1'b0, p_reg} + {1'b0, q_reg};
                count_next = '0;
                state_next = REDUCE;
            end
            REDUCE: begin
                if (m_reg == '0) begin
                    // Nothing meaningful to reduce by; pass the raw sum on.
                    range_set = 1'b1;
                    enter_out = 1'b1;
                end else if (sub_ge && (count_reg < MAX_SUB_C)) begin
                    sum_next   = sub_diff;
                    count_next = count_reg + 1'b1;
                end else begin
                    // Still >= m after the last allowed step: sizing
                    // assumption was violated, flag it but still deliver.
                    range_set = sub_ge;
                    enter_out = 1'b1;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    // A pulse coinciding with the handshake is accepted
                    // immediately so back-to-back results lose nothing.
                    if (bus.in_done) begin
                        capture    = 1'b1;
                        state_next = ADD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                out_valid_next = 1'b0;
            end
        endcase

        if (enter_out) begin
            state_next     = OUT;
            out_valid_next = 1'b1;
            out_r_next     = sum_reg[N-1:0];
        end

        if (capture) begin
            p_next = bus.in_p;
            q_next = bus.in_q;
            m_next = bus.in_m;
        end

        // Any pulse that was not captured has been dropped.
        overrun_set    = bus.in_done && !capture;

        // Setting events take priority over clear.
        overrun_next   = overrun_set | (overrun_reg   & ~bus.clear);
        range_err_next = range_set   | (range_err_reg & ~bus.clear);
        busy_next      = (state_next != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            p_reg         <= '0;
            q_reg         <= '0;
            m_reg         <= '0;
            sum_reg       <= '0;
            count_reg     <= '0;
            out_r_reg     <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            range_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            p_reg         <= p_next;
            q_reg         <= q_next;
            m_reg         <= m_next;
            sum_reg       <= sum_next;
            count_reg     <= count_next;
            out_r_reg     <= out_r_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
            overrun_reg   <= overrun_next;
            range_err_reg <= range_err_next;
        end
    end

    assign bus.out_r     = out_r_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.overrun   = overrun_reg;
    assign bus.range_err = range_err_reg;

endmodule

// File: tb/tb_main_collect.sv
// ---------------------------------------------------------------------------
// tb_main_collect
//   Scoreboard bench for main_collect (N=8, MAX_SUB=3). Stimulus pushes the
//   expected result, range flag and arrival cycle computed from p+q mod m
//   arithmetic; an independent monitor compares whenever a result appears.
// ---------------------------------------------------------------------------
module tb_main_collect;
    localparam int N       = 8;
    localparam int MAX_SUB = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    main_collect_if #(.N(N)) bus();

    main_collect #(.N(N), .MAX_SUB(MAX_SUB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] r;
        logic       err;
        int         due;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   n_id  = 0;
    bit   ready_rand = 1'b0;
    bit   ready_val  = 1'b1;
    bit   err_model  = 1'b0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: reduce p+q by m as far as MAX_SUB subtractions allow.
    function automatic exp_t model(input int p, input int q, input int m,
                                   input int issue, input int id);
        exp_t e;
        int s, k, s2;
        s = p + q;
        if (m == 0) begin
            k     = 0;
            e.r   = 8'(s % 256);
            e.err = 1'b1;
        end else begin
            k = s / m;
            if (k > MAX_SUB) k = MAX_SUB;
            s2    = s - k * m;
            e.err = (s2 >= m);
            e.r   = 8'(s2 % 256);
        end
        e.due = issue + 3 + k;
        e.id  = id;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        bus.out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_val;
    endtask

    task automatic issue(input int p, input int q, input int m, input bit track);
        exp_t e;
        bus.in_p    = 9'(p);
        bus.in_q    = 9'(q);
        bus.in_m    = 8'(m);
        bus.in_done = 1'b1;
        if (track) begin
            e         = model(p, q, m, cyc, n_id);
            n_id++;
            e.err     = e.err | err_model;
            err_model = e.err;
            sb.push_back(e);
            $display("[TB] issue #%0d p=%0d q=%0d m=%0d -> r=%0d err=%0d due=%0d",
                     e.id, p, q, m, e.r, e.err, e.due);
        end else begin
            $display("[TB] pulse (expected to be dropped) p=%0d q=%0d m=%0d", p, q, m);
        end
        tick();
        bus.in_done = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        err_model = 1'b0;
    endtask

    // Monitor: a result is "fresh" on the first cycle out_valid is seen for it.
    initial begin
        exp_t cur;
        bit prev_valid = 1'b0;
        bit prev_hs    = 1'b0;
        bit fresh, hs;
        cur = '{r: 8'd0, err: 1'b0, due: 0, id: -1};
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
            end else begin
                fresh = bus.out_valid && (!prev_valid || prev_hs);
                if (fresh) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_valid: out_valid=1 out_r=%0d at cycle %0d, required no result",
                                 bus.out_r, cyc);
                    end else begin
                        cur = sb[0];
                        check("result_r", 32'(bus.out_r), 32'(cur.r));
                        check("result_range_err", 32'(bus.range_err), 32'(cur.err));
                        check("result_latency", 32'(cyc), 32'(cur.due));
                        $display("[TB] result #%0d r=%0d err=%0d at cycle %0d",
                                 cur.id, bus.out_r, bus.range_err, cyc);
                    end
                end else if (bus.out_valid) begin
                    check("hold_r", 32'(bus.out_r), 32'(cur.r));
                end
                hs = bus.out_valid && bus.out_ready;
                if (hs && sb.size() != 0) void'(sb.pop_front());
                prev_valid = bus.out_valid;
                prev_hs    = hs;
            end
        end
    end

    initial begin
        int n;
        bus.in_p      = '0;
        bus.in_q      = '0;
        bus.in_m      = '0;
        bus.in_done   = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check("reset_out_r", 32'(bus.out_r), 0);
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_overrun", 32'(bus.overrun), 0);
        check("reset_range_err", 32'(bus.range_err), 0);
        reset = 1'b1;
        tick();

        // Basic reduce and no-reduction cases
        issue(20, 15, 13, 1'b1);
        check("busy_after_done", 32'(bus.busy), 1);
        drain();
        issue(3, 4, 13, 1'b1);
        drain();
        check("single_cycle_valid", 32'(bus.out_valid), 0);

        // Range error: bound exhausted, then m == 0
        issue(300, 200, 13, 1'b1);
        drain();
        do_clear();
        check("range_err_cleared", 32'(bus.range_err), 0);
        issue(300, 200, 0, 1'b1);
        drain();
        do_clear();

        // Backpressure then back-to-back capture on the handshake cycle
        ready_val     = 1'b0;
        bus.out_ready = 1'b0;
        issue(20, 15, 13, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_valid_seen", 32'(bus.out_valid), 1);
        repeat (5) begin
            tick();
            check("bp_valid_held", 32'(bus.out_valid), 1);
        end
        ready_val     = 1'b1;
        bus.out_ready = 1'b1;
        issue(1, 1, 13, 1'b1);
        drain();
        check("bp_no_overrun", 32'(bus.overrun), 0);

        // Overrun: pulse while reducing is dropped
        issue(20, 15, 13, 1'b1);
        tick();
        issue(99, 99, 50, 1'b0);
        drain();
        check("overrun_set", 32'(bus.overrun), 1);
        do_clear();
        check("overrun_cleared", 32'(bus.overrun), 0);

        // Reset mid-operation
        issue(20, 15, 13, 1'b0);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("midreset_out_r", 32'(bus.out_r), 0);
        check("midreset_valid", 32'(bus.out_valid), 0);
        check("midreset_busy", 32'(bus.busy), 0);
        check("midreset_range_err", 32'(bus.range_err), 0);
        err_model = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        repeat (8) tick();
        issue(3, 4, 13, 1'b1);
        drain();

        // Randomized traffic with random backpressure
        ready_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int p, q, m, sel;
            drain();
            if ($urandom_range(0, 3) == 0) begin
                do_clear();
                check("rand_clear", 32'(bus.range_err), 0);
            end
            p   = int'($urandom_range(0, 511));
            q   = int'($urandom_range(0, 511));
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      m = 0;
            else if (sel < 6)  m = int'($urandom_range(1, 255));
            else               m = int'($urandom_range(100, 255));
            issue(p, q, m, 1'b1);
        end
        drain();
        ready_rand = 1'b0;
        check("final_no_overrun", 32'(bus.overrun), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
